// File: rtl/row_stream_pkg.sv
// Shared types and helpers for the row/column streamer and its row-wide shifter.
package row_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_STREAM,
        WR_COLLECT,
        WR_PRESENT
    } state_t;

    localparam int DEF_COL_W   = 32;
    localparam int DEF_NUM_COL = 64;

    typedef logic [DEF_COL_W-1:0]             col_t;
    typedef logic [DEF_COL_W*DEF_NUM_COL-1:0] row_t;

    // Column counter width; a single-column row still needs one bit.
    function automatic int cnt_width(input int num_col);
        return (num_col < 2) ? 1 : $clog2(num_col);
    endfunction

endpackage

// File: rtl/row_wide_shifter.sv
// Row register of NUM_COL columns: parallel load, or one-column shift with a new
// column entering at the far end. Contents are not reset; consumers gate with valids.
module row_wide_shifter #(
    parameter int COL_W   = 32,
    parameter int NUM_COL = 64
) (
    input  logic                     clk,
    input  logic                     load_row,
    input  logic                     shift_signal,
    input  logic                     dir,
    input  logic [COL_W*NUM_COL-1:0] input_row,
    input  logic [COL_W-1:0]         input_column,
    output logic [COL_W*NUM_COL-1:0] row
);

    // dir=1 moves every column toward index 0 and inserts at index NUM_COL-1;
    // dir=0 moves toward the top index and inserts at index 0.
    always_ff @(posedge clk) begin
        if (load_row) begin
            row <= input_row;
        end else if (shift_signal) begin
            if (dir) begin
                row <= {input_column, row[COL_W*NUM_COL-1:COL_W]};
            end else begin
                row <= {row[COL_W*(NUM_COL-1)-1:0], input_column};
            end
        end
    end

endmodule

// File: rtl/row_column_streamer.sv
// Command-driven row<->column streamer around one row_wide_shifter.
// Build option ROW_STREAM_CIRCULAR_EN: reads rotate the row so it is intact afterwards.
module row_column_streamer
    import row_stream_pkg::*;
#(
    parameter int GOLOBAL_DATA_BUS_WIDTH = 32,
    parameter int NUM_OF_COL_IN_ROW      = 64,
    localparam int W     = GOLOBAL_DATA_BUS_WIDTH,
    localparam int N     = NUM_OF_COL_IN_ROW,
    localparam int CNT_W = cnt_width(NUM_OF_COL_IN_ROW)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [N*W-1:0]     row_in,
    output logic               col_out_valid,
    input  logic               col_out_ready,
    output logic [W-1:0]       col_out_data,
    input  logic               col_in_valid,
    output logic               col_in_ready,
    input  logic [W-1:0]       col_in_data,
    output logic               row_out_valid,
    input  logic               row_out_ready,
    output logic [N*W-1:0]     row_out,
    output logic               busy,
    output logic [CNT_W-1:0]   col_idx
);

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(N - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             sh_load;
    logic             sh_shift;
    logic             sh_dir;
    logic [W-1:0]     sh_col;
    logic [N*W-1:0]   sh_row;

    row_wide_shifter #(
        .COL_W   (W),
        .NUM_COL (N)
    ) u_shifter (
        .clk          (clk),
        .load_row     (sh_load),
        .shift_signal (sh_shift),
        .dir          (sh_dir),
        .input_row    (row_in),
        .input_column (sh_col),
        .row          (sh_row)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cmd_ready     = 1'b0;
        col_out_valid = 1'b0;
        col_in_ready  = 1'b0;
        row_out_valid = 1'b0;
        sh_load       = 1'b0;
        sh_shift      = 1'b0;
        sh_dir        = 1'b1;
        sh_col        = '0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cnt_nxt = '0;
                    if (cmd_write) begin
                        state_nxt = WR_COLLECT;
                    end else begin
                        sh_load   = 1'b1;
                        state_nxt = RD_STREAM;
                    end
                end
            end
            RD_STREAM: begin
                col_out_valid = 1'b1;
`ifdef ROW_STREAM_CIRCULAR_EN
                sh_col = sh_row[W-1:0];
`else
                sh_col = '0;
`endif
                if (col_out_ready) begin
                    sh_shift = 1'b1;
                    if (cnt == LAST_COL) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            WR_COLLECT: begin
                col_in_ready = 1'b1;
                sh_col       = col_in_data;
                if (col_in_valid) begin
                    sh_shift = 1'b1;
                    if (cnt == LAST_COL) begin
                        cnt_nxt   = '0;
                        state_nxt = WR_PRESENT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            WR_PRESENT: begin
                row_out_valid = 1'b1;
                if (row_out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign col_out_data = sh_row[W-1:0];
    assign row_out      = sh_row;
    assign busy         = (state != IDLE);
    assign col_idx      = cnt;

endmodule

// File: tb/tb_row_column_streamer.sv
// Directed bench for row_column_streamer at N=4 columns of 8 bits.
module tb_row_column_streamer;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_write;
    logic [N*W-1:0] row_in;
    logic           col_out_valid;
    logic           col_out_ready;
    logic [W-1:0]   col_out_data;
    logic           col_in_valid;
    logic           col_in_ready;
    logic [W-1:0]   col_in_data;
    logic           row_out_valid;
    logic           row_out_ready;
    logic [N*W-1:0] row_out;
    logic           busy;
    logic [1:0]     col_idx;

    int total_cnt;
    int pass_cnt;

    row_column_streamer #(
        .GOLOBAL_DATA_BUS_WIDTH (W),
        .NUM_OF_COL_IN_ROW      (N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .row_in        (row_in),
        .col_out_valid (col_out_valid),
        .col_out_ready (col_out_ready),
        .col_out_data  (col_out_data),
        .col_in_valid  (col_in_valid),
        .col_in_ready  (col_in_ready),
        .col_in_data   (col_in_data),
        .row_out_valid (row_out_valid),
        .row_out_ready (row_out_ready),
        .row_out       (row_out),
        .busy          (busy),
        .col_idx       (col_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus changes and checks both happen on the falling edge.
    task automatic do_reset();
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_write     = 1'b0;
        row_in        = '0;
        col_out_ready = 1'b0;
        col_in_valid  = 1'b0;
        col_in_data   = '0;
        row_out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [4:0] got;
        do_reset();
        got = {cmd_ready, busy, col_out_valid, col_in_ready, row_out_valid};
        total_cnt++;
        if (got !== 5'b10000) $display("FAIL reset_flags: got %b want 10000", got);
        else pass_cnt++;
        total_cnt++;
        if (col_idx !== 2'd0) $display("FAIL reset_col_idx: got %0d want 0", col_idx);
        else pass_cnt++;
    endtask

    task automatic test_read();
        logic [7:0] exp_col [4];
        exp_col = '{8'h11, 8'h22, 8'h33, 8'h44};
        cmd_valid     = 1'b1;
        cmd_write     = 1'b0;
        row_in        = 32'h4433_2211;
        col_out_ready = 1'b1;
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL rd_cmd_ready: got %b want 1", cmd_ready);
        else pass_cnt++;
        @(negedge clk);
        cmd_valid = 1'b0;
        row_in    = '0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (col_out_valid !== 1'b1 || col_out_data !== exp_col[i] || col_idx !== 2'(i))
                $display("FAIL rd_beat%0d: got v=%b d=%h idx=%0d want v=1 d=%h idx=%0d",
                         i, col_out_valid, col_out_data, col_idx, exp_col[i], i);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || col_out_valid !== 1'b0)
            $display("FAIL rd_done: got rdy=%b busy=%b v=%b want 1 0 0", cmd_ready, busy, col_out_valid);
        else pass_cnt++;
        total_cnt++;
`ifdef ROW_STREAM_CIRCULAR_EN
        if (row_out !== 32'h4433_2211) $display("FAIL rd_row_after: got %h want 44332211", row_out);
        else pass_cnt++;
`else
        if (row_out !== 32'h0000_0000) $display("FAIL rd_row_after: got %h want 00000000", row_out);
        else pass_cnt++;
`endif
        col_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_col [4];
        exp_col = '{8'h11, 8'h22, 8'h33, 8'h44};
        cmd_valid     = 1'b1;
        cmd_write     = 1'b0;
        row_in        = 32'h4433_2211;
        col_out_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        total_cnt++;
        if (col_out_data !== 8'h11) $display("FAIL bp_beat0: got %h want 11", col_out_data);
        else pass_cnt++;
        @(negedge clk);
        col_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (col_out_valid !== 1'b1 || col_out_data !== 8'h22 || col_idx !== 2'd1)
                $display("FAIL bp_hold%0d: got v=%b d=%h idx=%0d want v=1 d=22 idx=1",
                         i, col_out_valid, col_out_data, col_idx);
            else pass_cnt++;
            @(negedge clk);
        end
        col_out_ready = 1'b1;
        total_cnt++;
        if (col_out_data !== 8'h22) $display("FAIL bp_resume_hold: got %h want 22", col_out_data);
        else pass_cnt++;
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            total_cnt++;
            if (col_out_valid !== 1'b1 || col_out_data !== exp_col[i] || col_idx !== 2'(i))
                $display("FAIL bp_beat%0d: got v=%b d=%h idx=%0d want v=1 d=%h idx=%0d",
                         i, col_out_valid, col_out_data, col_idx, exp_col[i], i);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL bp_done: got busy=%b rdy=%b want 0 1", busy, cmd_ready);
        else pass_cnt++;
        col_out_ready = 1'b0;
    endtask

    task automatic test_write();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        total_cnt++;
        if (col_in_ready !== 1'b1 || busy !== 1'b1) $display("FAIL wr_ready: got rdy=%b busy=%b want 1 1", col_in_ready, busy);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            col_in_valid = 1'b1;
            col_in_data  = 8'hA0 + 8'(i);
            @(negedge clk);
            col_in_valid = 1'b0;
            col_in_data  = 8'h5A;
            if (i < 3) begin
                total_cnt++;
                if (col_idx !== 2'(i + 1) || row_out_valid !== 1'b0)
                    $display("FAIL wr_beat%0d: got idx=%0d rv=%b want idx=%0d rv=0", i, col_idx, row_out_valid, i + 1);
                else pass_cnt++;
                @(negedge clk);
            end
        end
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (row_out_valid !== 1'b1 || row_out !== 32'hA3A2_A1A0 || col_in_ready !== 1'b0)
                $display("FAIL wr_present%0d: got rv=%b row=%h cir=%b want rv=1 row=a3a2a1a0 cir=0",
                         i, row_out_valid, row_out, col_in_ready);
            else pass_cnt++;
            @(negedge clk);
        end
        row_out_ready = 1'b1;
        @(negedge clk);
        row_out_ready = 1'b0;
        total_cnt++;
        if (row_out_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL wr_done: got rv=%b rdy=%b want 0 1", row_out_valid, cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_cmd_while_busy();
        logic [7:0] exp_col [4];
        exp_col = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        cmd_valid     = 1'b1;
        cmd_write     = 1'b0;
        row_in        = 32'hDDCC_BBAA;
        col_out_ready = 1'b1;
        @(negedge clk);
        cmd_write = 1'b1;
        row_in    = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (cmd_ready !== 1'b0 || col_out_data !== exp_col[i])
                $display("FAIL busy_beat%0d: got rdy=%b d=%h want rdy=0 d=%h", i, cmd_ready, col_out_data, exp_col[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL busy_idle: got rdy=%b busy=%b want 1 0", cmd_ready, busy);
        else pass_cnt++;
        @(negedge clk);
        cmd_valid     = 1'b0;
        col_out_ready = 1'b0;
        total_cnt++;
        if (col_in_ready !== 1'b1 || busy !== 1'b1 || col_out_valid !== 1'b0)
            $display("FAIL busy_taken: got cir=%b busy=%b cov=%b want 1 1 0", col_in_ready, busy, col_out_valid);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] exp_col [4];
        exp_col = '{8'h0C, 8'h0D, 8'h0E, 8'h0F};
        cmd_valid     = 1'b1;
        cmd_write     = 1'b0;
        row_in        = 32'h4433_2211;
        col_out_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (col_out_data !== 8'h22 || col_idx !== 2'd1) $display("FAIL rst_pre: got d=%h idx=%0d want 22 1", col_out_data, col_idx);
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (col_out_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || col_idx !== 2'd0)
            $display("FAIL rst_abort: got v=%b busy=%b rdy=%b idx=%0d want 0 0 1 0", col_out_valid, busy, cmd_ready, col_idx);
        else pass_cnt++;
        @(negedge clk);
        rst_n     = 1'b1;
        cmd_valid = 1'b1;
        row_in    = 32'h0F0E_0D0C;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (col_out_valid !== 1'b1 || col_out_data !== exp_col[i] || col_idx !== 2'(i))
                $display("FAIL rst_next_beat%0d: got v=%b d=%h idx=%0d want v=1 d=%h idx=%0d",
                         i, col_out_valid, col_out_data, col_idx, exp_col[i], i);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL rst_next_done: got busy=%b want 0", busy);
        else pass_cnt++;
        col_out_ready = 1'b0;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        test_reset();
        test_read();
        test_backpressure();
        test_write();
        test_cmd_while_busy();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
